// File: rtl/multispi_pkg.sv
// Shared constants for the multi-channel SPI master: register map defaults,
// CFG/STAT bit positions and the shift-engine state encoding.
package multispi_pkg;

  localparam logic [7:0] REG_DATA_DEF = 8'h02;
  localparam logic [7:0] REG_CS_DEF   = 8'h30;
  localparam logic [7:0] REG_CFG_DEF  = 8'h31;
  localparam logic [7:0] REG_STAT_DEF = 8'h32;

  localparam int CFG_CPHA    = 0;
  localparam int CFG_CPOL    = 1;
  localparam int CFG_LSB     = 2;
  localparam int CFG_DIV_LSB = 3;

  localparam int STAT_BUSY    = 7;
  localparam int STAT_CS_NONE = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } spi_state_t;

endpackage

// File: rtl/multispi_master_spi_shift_engine.sv
// Single-byte SPI shift engine: 16 half-period phases, programmable divider,
// all four modes and selectable bit order.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | sclk parked at CPOL, mosi high, waiting for start
//   ST_SHIFT | 16 half-period phases; even phases end with a MISO sample,
//            | odd phases end with a shift
//   ST_DONE  | one cycle: shifter copied into rx, then back to idle
module spi_shift_engine
  import multispi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx,
  input  logic [7:0] cfg,
  input  logic       miso,
  output logic       busy,
  output logic [7:0] rx,
  output logic       sclk,
  output logic       mosi
);

  spi_state_t state, state_nxt;
  logic [3:0] phase;
  logic [4:0] div_cnt;
  logic [7:0] shreg;
  logic       samp;
  logic [4:0] div_val;
  logic       lsb_first;
  logic       div_tc;

  assign div_val   = cfg[7:CFG_DIV_LSB];
  assign lsb_first = cfg[CFG_LSB];
  assign div_tc    = (div_cnt == 5'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (div_tc && phase == 4'd15) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Modes with CPHA=1 only invert the clock within the transfer; the
  // sample/shift points land on the same phases in every mode.
  always_comb begin
    busy = (state != ST_IDLE);
    sclk = cfg[CFG_CPOL];
    mosi = 1'b1;
    if (state == ST_SHIFT) begin
      sclk = cfg[CFG_CPOL] ^ cfg[CFG_CPHA] ^ phase[0];
      mosi = lsb_first ? shreg[0] : shreg[7];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase   <= 4'd0;
      div_cnt <= 5'd0;
      shreg   <= 8'hFF;
      samp    <= 1'b1;
      rx      <= 8'hFF;
    end else if (state == ST_IDLE && start) begin
      shreg   <= tx;
      phase   <= 4'd0;
      div_cnt <= div_val;
    end else if (state == ST_SHIFT) begin
      if (div_tc) begin
        div_cnt <= div_val;
        phase   <= phase + 4'd1;
        if (!phase[0])      samp  <= miso;
        else if (lsb_first) shreg <= {samp, shreg[7:1]};
        else                shreg <= {shreg[6:0], samp};
      end else begin
        div_cnt <= div_cnt - 5'd1;
      end
    end else if (state == ST_DONE) begin
      rx <= shreg;
    end
  end

endmodule

// File: rtl/multispi_master.sv
// ZX-UNO register-mapped SPI master: register decode, chip-select register,
// per-channel MISO mux and CPU stall around a shared shift engine.
module multispi_master
  import multispi_pkg::*;
#(
  parameter int         NCS      = 16,
  parameter int         CSW      = 4,
  parameter logic [7:0] REG_DATA = REG_DATA_DEF,
  parameter logic [7:0] REG_CS   = REG_CS_DEF,
  parameter logic [7:0] REG_CFG  = REG_CFG_DEF,
  parameter logic [7:0] REG_STAT = REG_STAT_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [7:0]     addr,
  input  logic           ior,
  input  logic           iow,
  input  logic [7:0]     din,
  output logic [7:0]     dout,
  output logic           oe_n,
  output logic           wait_n,
  output logic           spi_clk,
  output logic           spi_mosi,
  input  logic [NCS-1:0] spi_miso,
  output logic [NCS-1:0] spi_cs_n
);

  localparam logic [7:0] NCS_LIM = 8'(NCS);

  logic           ior_q, iow_q;
  logic [7:0]     cfg;
  logic           cs_none;
  logic [CSW-1:0] cs_idx;
  logic           pend_valid, pend_wr;
  logic [7:0]     pend_addr, pend_din;

  logic           rd_edge, wr_edge;
  logic           exec_valid, exec_wr, capture, stall;
  logic [7:0]     exec_addr, exec_din;
  logic           busy, start, miso_sel;
  logic [7:0]     tx, rx, cs_rd, stat_rd;

  function automatic logic is_stall_reg(input logic [7:0] a);
    return (a == REG_DATA) || (a == REG_CS) || (a == REG_CFG);
  endfunction

  assign rd_edge = ior && !ior_q;
  assign wr_edge = iow && !iow_q;

  // A pending (stalled) access replays on the first non-busy cycle.
  always_comb begin
    exec_valid = 1'b0;
    exec_wr    = 1'b0;
    exec_addr  = addr;
    exec_din   = din;
    capture    = 1'b0;
    stall      = 1'b0;
    if (pend_valid) begin
      if (busy) begin
        stall = 1'b1;
      end else begin
        exec_valid = 1'b1;
        exec_wr    = pend_wr;
        exec_addr  = pend_addr;
        exec_din   = pend_din;
      end
    end else if (rd_edge || wr_edge) begin
      if (busy && is_stall_reg(addr)) begin
        capture = 1'b1;
        stall   = 1'b1;
      end else begin
        exec_valid = 1'b1;
        exec_wr    = wr_edge;
      end
    end
  end

  assign wait_n = !stall;
  assign start  = exec_valid && (exec_addr == REG_DATA);
  assign tx     = exec_wr ? exec_din : 8'hFF;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ior_q      <= 1'b0;
      iow_q      <= 1'b0;
      cfg        <= 8'h00;
      cs_none    <= 1'b1;
      cs_idx     <= '0;
      pend_valid <= 1'b0;
      pend_wr    <= 1'b0;
      pend_addr  <= 8'h00;
      pend_din   <= 8'h00;
    end else begin
      ior_q <= ior;
      iow_q <= iow;
      if (capture) begin
        pend_valid <= 1'b1;
        pend_wr    <= wr_edge;
        pend_addr  <= addr;
        pend_din   <= din;
      end else if (exec_valid) begin
        pend_valid <= 1'b0;
      end
      if (exec_valid && exec_wr && exec_addr == REG_CFG) cfg <= exec_din;
      // Any set bit above the channel range also deselects everything.
      if (exec_valid && exec_wr && exec_addr == REG_CS) begin
        cs_none <= exec_din[7] || ({1'b0, exec_din[6:0]} >= NCS_LIM);
        cs_idx  <= exec_din[CSW-1:0];
      end
    end
  end

  always_comb begin
    spi_cs_n = '1;
    miso_sel = 1'b1;
    for (int i = 0; i < NCS; i++) begin
      if (!cs_none && cs_idx == CSW'(i)) begin
        spi_cs_n[i] = 1'b0;
        miso_sel    = spi_miso[i];
      end
    end
  end

  always_comb begin
    cs_rd               = 8'h00;
    cs_rd[7]            = cs_none;
    cs_rd[CSW-1:0]      = cs_idx;
    stat_rd             = 8'h00;
    stat_rd[STAT_BUSY]    = busy;
    stat_rd[STAT_CS_NONE] = cs_none;
  end

  always_comb begin
    oe_n = !(ior && (is_stall_reg(addr) || addr == REG_STAT) && wait_n);
    dout = 8'h00;
    if (!oe_n) begin
      if (addr == REG_DATA)     dout = rx;
      else if (addr == REG_CS)  dout = cs_rd;
      else if (addr == REG_CFG) dout = cfg;
      else                      dout = stat_rd;
    end
  end

  spi_shift_engine u_engine (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .tx    (tx),
    .cfg   (cfg),
    .miso  (miso_sel),
    .busy  (busy),
    .rx    (rx),
    .sclk  (spi_clk),
    .mosi  (spi_mosi)
  );

endmodule
